// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Handshaked, parametrised ALU with a registered result and a
//            {V,C,N,Z} flag nibble. Single-cycle ops complete in one cycle.
//            An optional iterative shift-add multiplier is built only when
//            ALU_PIPE_MUL_EN is defined. Without it, op 9 decodes as ADD.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [3:0]       flags_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NAND = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;

  logic [WIDTH-1:0] alu_res_d;
  logic [3:0]       alu_flags_d;
  logic             accept;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q;
  logic [SHW:0]       cnt_q;
  logic [2*WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;
  logic [2*WIDTH-1:0] acc_q;

  // Accept only when idle and the output register is free or draining now.
  assign in_ready_o = rst_n && (state_q == S_IDLE) && (!out_valid_o || out_ready_i);
`else
  // Without a multiplier the block is always idle; only the output matters.
  assign in_ready_o = rst_n && (!out_valid_o || out_ready_i);
`endif

  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign flags_o     = flags_q;

  // Single-cycle datapath: result and flags for every non-multiply opcode.
  always_comb begin
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   shl_idx;
    logic [SHW-1:0]   shr_idx;
    logic             c;
    logic             v;
    sum     = {1'b0, a_i} + {1'b0, b_i};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    amt     = b_i[SHW-1:0];
    // WIDTH is a power of two, so these wrap to WIDTH-amt and amt-1.
    shl_idx = {SHW{1'b0}} - amt;
    shr_idx = amt - 1'b1;
    alu_res_d = sum[WIDTH-1:0];
    c         = sum[WIDTH];
    v         = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
    case (op_i)
      OP_SUB: begin
        alu_res_d = diff[WIDTH-1:0];
        c         = diff[WIDTH];
        v         = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_NAND: begin alu_res_d = ~(a_i & b_i); c = 1'b0; v = 1'b0; end
      OP_AND:  begin alu_res_d = a_i & b_i;    c = 1'b0; v = 1'b0; end
      OP_OR:   begin alu_res_d = a_i | b_i;    c = 1'b0; v = 1'b0; end
      OP_XOR:  begin alu_res_d = a_i ^ b_i;    c = 1'b0; v = 1'b0; end
      OP_SHL: begin
        alu_res_d = a_i << amt;
        c         = (amt != '0) ? a_i[shl_idx] : 1'b0;
        v         = 1'b0;
      end
      OP_SHR: begin
        alu_res_d = a_i >> amt;
        c         = (amt != '0) ? a_i[shr_idx] : 1'b0;
        v         = 1'b0;
      end
      OP_SRA: begin
        alu_res_d = $unsigned($signed(a_i) >>> amt);
        c         = (amt != '0) ? a_i[shr_idx] : 1'b0;
        v         = 1'b0;
      end
      default: ; // ADD, opcodes 10-15, and op 9 when no multiplier is built
    endcase
    alu_flags_d = {v, c, alu_res_d[WIDTH-1], (alu_res_d == '0)};
  end

  // Control FSM, multiplier iteration and registered output with hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
`endif
    end else begin
`ifdef ALU_PIPE_MUL_EN
      if (state_q == S_MUL) begin
        if (cnt_q != '0) begin
          if (mul_b_q[0]) acc_q <= acc_q + mul_a_q;
          mul_a_q <= mul_a_q << 1;
          mul_b_q <= mul_b_q >> 1;
          cnt_q   <= cnt_q - 1'b1;
        end else begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b1;
          result_q    <= acc_q[WIDTH-1:0];
          flags_q     <= {|acc_q[2*WIDTH-1:WIDTH], |acc_q[2*WIDTH-1:WIDTH],
                          acc_q[WIDTH-1], (acc_q[WIDTH-1:0] == '0)};
        end
      end else if (accept && (op_i == OP_MUL)) begin
        state_q     <= S_MUL;
        cnt_q       <= (SHW+1)'(WIDTH);
        mul_a_q     <= {{WIDTH{1'b0}}, a_i};
        mul_b_q     <= b_i;
        acc_q       <= '0;
        out_valid_q <= 1'b0;
      end else
`endif
      if (accept) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res_d;
        flags_q     <= alu_flags_d;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
